// File: rtl/bf_sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage, 16 lanes per block.
// Ports: clk, rstn (async, active-low); din_valid/din_ready + din_real/imag
//   input blocks; sr_write/sr_read + sr_din_*/sr_dout_* external delay line;
//   dout_valid/dout_half + dout_real/imag output blocks; err sticky flag.
// Optional macro BF_SDF_SCALE_EN: halve (floor) sums and diffs.
module bf_sdf_stage #(
    parameter int WIDTH        = 9,
    parameter int DELAY_LENGTH = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic signed [WIDTH-1:0] din_real     [0:15],
    input  logic signed [WIDTH-1:0] din_imag     [0:15],
    output logic                    sr_write,
    output logic                    sr_read,
    output logic signed [WIDTH:0]   sr_din_real  [0:15],
    output logic signed [WIDTH:0]   sr_din_imag  [0:15],
    input  logic signed [WIDTH:0]   sr_dout_real [0:15],
    input  logic signed [WIDTH:0]   sr_dout_imag [0:15],
    output logic                    dout_valid,
    output logic                    dout_half,
    output logic signed [WIDTH:0]   dout_real    [0:15],
    output logic signed [WIDTH:0]   dout_imag    [0:15],
    output logic                    err
);

    localparam int CW = (DELAY_LENGTH > 1) ? $clog2(DELAY_LENGTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DELAY_LENGTH - 1);

    typedef enum logic [1:0] {
        FILL,
        BFLY,
        FLUSH,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   blk_cnt;
    logic [CW-1:0]   cnt_nx;
    logic            accept;
    logic            err_set;
    logic            bfly_v;
    logic            drain_v;

    logic signed [WIDTH:0] b_re   [0:15];
    logic signed [WIDTH:0] b_im   [0:15];
    logic signed [WIDTH:0] sum_re [0:15];
    logic signed [WIDTH:0] sum_im [0:15];
    logic signed [WIDTH:0] dif_re [0:15];
    logic signed [WIDTH:0] dif_im [0:15];

    assign accept = din_valid & din_ready;

    // A missing block inside the butterfly half breaks the pairing with
    // the stored first half; only flagged once the half has started.
    assign err_set = (state == BFLY) && !din_valid && (blk_cnt != '0);

    always_comb begin
        state_nx  = state;
        cnt_nx    = blk_cnt;
        din_ready = 1'b0;
        sr_read   = 1'b0;
        unique case (state)
            FILL: begin
                din_ready = 1'b1;
                if (accept) begin
                    if (blk_cnt == LAST) begin
                        state_nx = BFLY;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = blk_cnt + CW'(1);
                    end
                end
            end
            BFLY: begin
                din_ready = 1'b1;
                sr_read   = accept;
                if (accept) begin
                    if (blk_cnt == LAST) begin
                        state_nx = FLUSH;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = blk_cnt + CW'(1);
                    end
                end
            end
            FLUSH: begin
                state_nx = DRAIN;
                cnt_nx   = '0;
            end
            DRAIN: begin
                sr_read = 1'b1;
                if (blk_cnt == LAST) begin
                    state_nx = FILL;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = blk_cnt + CW'(1);
                end
            end
            default: begin
                state_nx = FILL;
                cnt_nx   = '0;
            end
        endcase
    end

    // Scaling is applied once, when sum/diff are formed; the diff is
    // written back already scaled, so drained values pass through as-is.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sum_re[i] = sr_dout_real[i] + b_re[i];
            sum_im[i] = sr_dout_imag[i] + b_im[i];
            dif_re[i] = sr_dout_real[i] - b_re[i];
            dif_im[i] = sr_dout_imag[i] - b_im[i];
`ifdef BF_SDF_SCALE_EN
            sum_re[i] = sum_re[i] >>> 1;
            sum_im[i] = sum_im[i] >>> 1;
            dif_re[i] = dif_re[i] >>> 1;
            dif_im[i] = dif_im[i] >>> 1;
`endif
        end
    end

    // Fill writes and diff write-backs never overlap: bfly_v is only
    // high in BFLY/FLUSH.
    always_comb begin
        sr_write = ((state == FILL) && din_valid) || bfly_v;
        for (int i = 0; i < 16; i++) begin
            sr_din_real[i] = '0;
            sr_din_imag[i] = '0;
            if (bfly_v) begin
                sr_din_real[i] = dif_re[i];
                sr_din_imag[i] = dif_im[i];
            end else if ((state == FILL) && din_valid) begin
                sr_din_real[i] = {din_real[i][WIDTH-1], din_real[i]};
                sr_din_imag[i] = {din_imag[i][WIDTH-1], din_imag[i]};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= FILL;
            blk_cnt    <= '0;
            err        <= 1'b0;
            bfly_v     <= 1'b0;
            drain_v    <= 1'b0;
            dout_valid <= 1'b0;
            dout_half  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                b_re[i]      <= '0;
                b_im[i]      <= '0;
                dout_real[i] <= '0;
                dout_imag[i] <= '0;
            end
        end else begin
            state   <= state_nx;
            blk_cnt <= cnt_nx;
            err     <= err | err_set;
            bfly_v  <= (state == BFLY) && accept;
            drain_v <= (state == DRAIN);
            if ((state == BFLY) && accept) begin
                for (int i = 0; i < 16; i++) begin
                    b_re[i] <= {din_real[i][WIDTH-1], din_real[i]};
                    b_im[i] <= {din_imag[i][WIDTH-1], din_imag[i]};
                end
            end
            dout_valid <= bfly_v | drain_v;
            dout_half  <= drain_v & ~bfly_v;
            for (int i = 0; i < 16; i++) begin
                if (bfly_v) begin
                    dout_real[i] <= sum_re[i];
                    dout_imag[i] <= sum_im[i];
                end else if (drain_v) begin
                    dout_real[i] <= sr_dout_real[i];
                    dout_imag[i] <= sr_dout_imag[i];
                end else begin
                    dout_real[i] <= '0;
                    dout_imag[i] <= '0;
                end
            end
        end
    end

endmodule
